// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, parity encodings and frame geometry
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} rx_state_e;
    localparam logic [1:0] PAR_NONE  = 2'b00;
    localparam logic [1:0] PAR_ODD   = 2'b01;
    localparam logic [1:0] PAR_EVEN  = 2'b10;
    localparam logic [1:0] PAR_NONE2 = 2'b11;
    localparam int DATA_BITS_DEF = 8;
    localparam int FRAME_BITS = DATA_BITS_DEF + 3;
endpackage

// File: rtl/uart_rx_deser_if.sv
// uart_rx_deser_if: received-byte holding register handshake with status flags
interface uart_rx_deser_if #(parameter int DATA_BITS = 8);
    logic [DATA_BITS-1:0] rx_word;
    logic rx_valid;
    logic rx_ready;
    logic rx_parity_err;
    logic rx_frame_err;
    logic rx_overrun;
    modport master(output rx_word, rx_valid, rx_parity_err, rx_frame_err, rx_overrun, input rx_ready);
    modport slave(input rx_word, rx_valid, rx_parity_err, rx_frame_err, rx_overrun, output rx_ready);
endinterface

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: bit-period counter with half/full-bit terminal strobes; period latched on load
module uart_bit_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        clr,
    input  logic [31:0] n,
    output logic        half_tc,
    output logic        full_tc
);
    logic [31:0] cnt_q, cnt_d, per_q, per_d;
    always_comb begin
        per_d = load ? (n < 32'd2 ? 32'd2 : n) : per_q;
        cnt_d = (load || clr) ? '0 : cnt_q + 32'd1;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            per_q <= 32'd2;
        end else begin
            cnt_q <= cnt_d;
            per_q <= per_d;
        end
    end
    assign half_tc = cnt_q == (per_q >> 1) - 32'd1;
    assign full_tc = cnt_q == per_q - 32'd1;
endmodule

// File: rtl/uart_rx_deser.sv
// uart_rx_deser: UART receive deserializer feeding a valid/ready holding register
module uart_rx_deser
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_data,
    input  logic [31:0] cfg_clkSpeed_over_bdRate,
    input  logic [1:0]  cfg_parity_setting,
    output logic        rx_busy,
    uart_rx_deser_if.master rx
);
    localparam int CW = $clog2(DATA_BITS + 1);
    rx_state_e state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0] bitcnt_q, bitcnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d, word_q, word_d;
    logic perr_q, perr_d, ferr_q, ferr_d, commit_q, commit_d;
    logic valid_q, valid_d, operr_q, operr_d, oferr_q, oferr_d, ovr_q, ovr_d;
    logic rxs, load, clr, half_tc, full_tc, take;
    assign rxs = sync_q[SYNC_STAGES-1];
    uart_bit_timer u_timer (
        .clk(clk), .rst_n(rst_n), .load(load), .clr(clr),
        .n(cfg_clkSpeed_over_bdRate), .half_tc(half_tc), .full_tc(full_tc)
    );
    always_comb begin
        sync_d   = SYNC_STAGES'({sync_q, rx_data});
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        perr_d   = perr_q;
        ferr_d   = ferr_q;
        commit_d = 1'b0;
        load     = 1'b0;
        clr      = 1'b0;
        case (state_q)
            IDLE: begin
                clr = 1'b1;
                if (!rxs) begin
                    load    = 1'b1;
                    state_d = START;
                end
            end
            START: if (half_tc) begin
                clr      = 1'b1;
                bitcnt_d = '0;
                state_d  = rxs ? IDLE : DATA;
            end
            DATA: if (full_tc) begin
                clr      = 1'b1;
                shreg_d  = {rxs, shreg_q[DATA_BITS-1:1]};
                bitcnt_d = bitcnt_q + CW'(1);
                state_d  = bitcnt_q == CW'(DATA_BITS - 1) ? PARITY : DATA;
            end
            PARITY: if (full_tc) begin
                clr     = 1'b1;
                perr_d  = (cfg_parity_setting == PAR_ODD && !(^shreg_q ^ rxs)) ||
                          (cfg_parity_setting == PAR_EVEN && (^shreg_q ^ rxs));
                state_d = STOP;
            end
            STOP: if (full_tc) begin
                clr      = 1'b1;
                ferr_d   = !rxs;
                commit_d = 1'b1;
                state_d  = rxs ? IDLE : WAIT_HIGH;
            end
            WAIT_HIGH: begin
                clr     = 1'b1;
                state_d = rxs ? IDLE : WAIT_HIGH;
            end
            default: state_d = IDLE;
        endcase
    end
    // a commit lands only when the holding register is empty or being drained this cycle
    always_comb begin
        take    = commit_q && (!valid_q || rx.rx_ready);
        word_d  = take ? shreg_q : word_q;
        operr_d = take ? perr_q : operr_q;
        oferr_d = take ? ferr_q : oferr_q;
        valid_d = take || (valid_q && !rx.rx_ready);
        ovr_d   = ovr_q || (commit_q && valid_q && !rx.rx_ready);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sync_q   <= '1;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            commit_q <= 1'b0;
            word_q   <= '0;
            valid_q  <= 1'b0;
            operr_q  <= 1'b0;
            oferr_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
            commit_q <= commit_d;
            word_q   <= word_d;
            valid_q  <= valid_d;
            operr_q  <= operr_d;
            oferr_q  <= oferr_d;
            ovr_q    <= ovr_d;
        end
    end
    assign rx.rx_word       = word_q;
    assign rx.rx_valid      = valid_q;
    assign rx.rx_parity_err = operr_q;
    assign rx.rx_frame_err  = oferr_q;
    assign rx.rx_overrun    = ovr_q;
    assign rx_busy          = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx_deser.sv
// tb_uart_rx_deser: table, random and hand-written sequence checks of the UART receiver
module tb_uart_rx_deser;
    import uart_pkg::*;
    logic clk = 1'b0, rst_n = 1'b0, rx_data = 1'b1, rx_busy;
    logic [31:0] cfg_n = 32'd16;
    logic [1:0] cfg_par = 2'b00;
    int total = 0, bad = 0;
    typedef struct packed {logic [7:0] w; logic pe; logic fe;} cap_t;
    typedef struct {int n; logic [1:0] par; logic [7:0] d; logic p; logic stop; logic pe; logic fe;} vec_t;
    cap_t got[$];
    vec_t vt[9];
    uart_rx_deser_if #(.DATA_BITS(8)) rxif();
    uart_rx_deser #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data),
        .cfg_clkSpeed_over_bdRate(cfg_n), .cfg_parity_setting(cfg_par),
        .rx_busy(rx_busy), .rx(rxif)
    );
    always #5 clk = ~clk;
    always @(negedge clk)
        if (rst_n && rxif.rx_valid && rxif.rx_ready)
            got.push_back('{rxif.rx_word, rxif.rx_parity_err, rxif.rx_frame_err});
    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask
    function automatic int neff(input int n);
        return n < 2 ? 2 : n;
    endfunction
    task automatic drive_bit(input logic b, input int nc);
        rx_data = b;
        tick(nc);
    endtask
    task automatic send(input logic [7:0] d, input logic p, input logic stop, input int stop_bits);
        int c;
        logic [FRAME_BITS-2:0] fr;
        c = neff(int'(cfg_n));
        fr = {p, d, 1'b0};
        for (int i = 0; i < FRAME_BITS - 1; i++) drive_bit(fr[i], c);
        drive_bit(stop, c * stop_bits);
        rx_data = 1'b1;
    endtask
    task automatic check_one(input string name, input logic [7:0] w, input logic pe, input logic fe);
        check({name, "_count"}, got.size(), 1);
        if (got.size() > 0) begin
            check({name, "_word"}, got[0].w, w);
            check({name, "_perr"}, got[0].pe, pe);
            check({name, "_ferr"}, got[0].fe, fe);
        end
    endtask
    initial begin
        vt[0] = '{16, 2'b01, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[1] = '{16, 2'b10, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[2] = '{16, 2'b00, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[3] = '{16, 2'b11, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[4] = '{8,  2'b01, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0};
        vt[5] = '{5,  2'b10, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[6] = '{3,  2'b01, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[7] = '{16, 2'b01, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[8] = '{7,  2'b10, 8'h7F, 1'b0, 1'b1, 1'b1, 1'b0};
        rxif.rx_ready = 1'b1;
        tick(3);
        @(negedge clk);
        check("rst_valid", rxif.rx_valid, 0);
        check("rst_word", rxif.rx_word, 0);
        check("rst_perr", rxif.rx_parity_err, 0);
        check("rst_ferr", rxif.rx_frame_err, 0);
        check("rst_ovr", rxif.rx_overrun, 0);
        check("rst_busy", rx_busy, 0);
        rst_n = 1'b1;
        tick(5);
        foreach (vt[i]) begin
            cfg_n = vt[i].n;
            cfg_par = vt[i].par;
            got.delete();
            send(vt[i].d, vt[i].p, vt[i].stop, 1);
            tick(2 * neff(vt[i].n) + 8);
            check_one($sformatf("vec%0d", i), vt[i].d, vt[i].pe, vt[i].fe);
        end
        for (int k = 0; k < 30; k++) begin
            logic [7:0] d;
            logic p, stop, pe;
            int ones;
            cfg_n = $urandom_range(2, 12);
            cfg_par = 2'($urandom_range(0, 3));
            d = 8'($urandom);
            p = 1'($urandom_range(0, 1));
            stop = $urandom_range(0, 3) != 0;
            ones = $countones(d) + int'(p);
            pe = (cfg_par == PAR_ODD && ones % 2 == 0) || (cfg_par == PAR_EVEN && ones % 2 == 1);
            got.delete();
            send(d, p, stop, 1);
            tick(2 * int'(cfg_n) + 8);
            check_one($sformatf("rnd%0d", k), d, pe, !stop);
        end
        cfg_n = 16;
        cfg_par = PAR_NONE;
        got.delete();
        rx_data = 1'b0;
        tick(5);
        rx_data = 1'b1;
        @(negedge clk);
        check("glitch_busy_mid", rx_busy, 1);
        tick(20);
        @(negedge clk);
        check("glitch_busy_end", rx_busy, 0);
        check("glitch_no_valid", got.size(), 0);
        got.delete();
        send(8'h3C, 1'b0, 1'b0, 3);
        tick(40);
        check_one("break", 8'h3C, 1'b0, 1'b1);
        got.delete();
        send(8'h55, 1'b0, 1'b1, 1);
        tick(40);
        check_one("after_break", 8'h55, 1'b0, 1'b0);
        cfg_par = PAR_NONE2;
        rxif.rx_ready = 1'b0;
        got.delete();
        send(8'h11, 1'b0, 1'b1, 1);
        tick(40);
        @(negedge clk);
        check("ovr_first_valid", rxif.rx_valid, 1);
        check("ovr_first_flag", rxif.rx_overrun, 0);
        send(8'h22, 1'b1, 1'b1, 1);
        tick(40);
        @(negedge clk);
        check("ovr_word_held", rxif.rx_word, 8'h11);
        check("ovr_set", rxif.rx_overrun, 1);
        check("ovr_valid_held", rxif.rx_valid, 1);
        tick(1);
        rxif.rx_ready = 1'b1;
        tick(1);
        @(negedge clk);
        check("ovr_drained", rxif.rx_valid, 0);
        check("ovr_sticky", rxif.rx_overrun, 1);
        check_one("ovr_accepted", 8'h11, 1'b0, 1'b0);
        cfg_n = 1;
        cfg_par = PAR_ODD;
        got.delete();
        send(8'h00, 1'b1, 1'b1, 1);
        send(8'hFF, 1'b1, 1'b1, 1);
        tick(20);
        check("b2b_count", got.size(), 2);
        if (got.size() == 2) begin
            check("b2b_word0", got[0].w, 8'h00);
            check("b2b_word1", got[1].w, 8'hFF);
            check("b2b_perr", {got[0].pe, got[1].pe}, 0);
        end
        cfg_n = 16;
        cfg_par = PAR_NONE;
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 16);
        drive_bit(1'b0, 16);
        drive_bit(1'b0, 8);
        rst_n = 1'b0;
        rx_data = 1'b1;
        tick(1);
        @(negedge clk);
        check("midrst_valid", rxif.rx_valid, 0);
        check("midrst_word", rxif.rx_word, 0);
        check("midrst_ovr", rxif.rx_overrun, 0);
        check("midrst_flags", {rxif.rx_parity_err, rxif.rx_frame_err}, 0);
        check("midrst_busy", rx_busy, 0);
        rst_n = 1'b1;
        tick(20);
        got.delete();
        send(8'h81, 1'b0, 1'b1, 1);
        tick(40);
        check_one("post_rst", 8'h81, 1'b0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_deser.md
Name: uart_rx_deser

Overview:
Receive-side deserializer for the UART block. It consumes the serial line driven by a peer UART transmitter and rebuilds the 11-bit frame the transmitter emits: start, 8 data bits LSB first, parity slot, stop. It presents each received byte on a valid/ready holding register with parity, framing and overrun flags. It sits between the rx_data pad and the downstream byte consumer, and shares cfg_clkSpeed_over_bdRate and cfg_parity_setting with the transmitter.

Parameters:
DATA_BITS, 8, data bits per frame (frame is always DATA_BITS+3 bits)
SYNC_STAGES, 2, flip-flop stages on rx_data before use

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  synchronous active-low reset
rx_data  in  1  asynchronous serial line, idle high
cfg_clkSpeed_over_bdRate  in  32  clk cycles per bit (N)
cfg_parity_setting  in  2  00 none, 01 odd, 10 even, 11 none
rx_word  out  DATA_BITS  received byte, stable while rx_valid=1
rx_valid  out  1  holding register full
rx_ready  in  1  consumer accepts when rx_valid & rx_ready
rx_parity_err  out  1  parity mismatch for rx_word; qualified by rx_valid
rx_frame_err  out  1  stop bit sampled low for rx_word; qualified by rx_valid
rx_overrun  out  1  sticky; a frame completed while rx_valid=1 and rx_ready=0
rx_busy  out  1  state /= IDLE

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; bit timer=0; bit count=0; synchronizer=all 1. Outputs rx_word=0, rx_valid=0, rx_parity_err=0, rx_frame_err=0, rx_overrun=0, rx_busy=0. Reset mid-frame abandons the frame with no output.
- Effective N: Neff = max(N,2). The value is latched at start-bit detection and does not change within the frame. Half-bit = floor(Neff/2).
- The synchronizer gives SYNC_STAGES cycles of latency. All decisions use the synchronized line rxs.
- States:
  - IDLE: rxs=0 -> START, timer=0.
  - START: at timer = half-bit-1, sample. If rxs=1 (glitch) -> IDLE with no flags. If rxs=0 -> DATA, timer=0, bitcnt=0.
  - DATA: at timer = Neff-1, shift rxs into bit bitcnt (LSB first), timer=0. After DATA_BITS samples -> PARITY.
  - PARITY: at timer = Neff-1, sample parity bit p -> STOP.
    - odd (01): err when ^data ^ p = 0.
    - even (10): err when ^data ^ p = 1.
    - 00/11: slot sampled but never flagged.
  - STOP: at timer = Neff-1, sample stop bit; frame_err = ~rxs. Commit, then:
    - if stop was high -> IDLE;
    - if stop was low (break) -> WAIT_HIGH.
  - WAIT_HIGH: stay until rxs=1, then go to IDLE. This prevents re-triggering on a held-low line.
- Commit: on the cycle after the stop sample, with rx_valid=0, or rx_valid=1 & rx_ready=1 in the same cycle (accept and refill are simultaneous, with no bubble):
  - rx_word, rx_parity_err and rx_frame_err load;
  - rx_valid=1.
- Overrun: commit while rx_valid=1 & rx_ready=0. The new frame is dropped, the held word is kept, and rx_overrun is set. rx_overrun clears only on reset.
- Accept: rx_valid & rx_ready with no commit -> rx_valid=0 next cycle. rx_word holds its last value.
- Latency: stop-bit mid-sample edge +1 clk -> rx_valid=1.
- Timer is 32-bit and compared with equality. It never wraps within a bit because it resets at each sample.
- cfg_parity_setting is sampled at the PARITY sample.

Decomposition:
- Package uart_pkg:
  - rx state enum (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH);
  - parity encoding constants (PAR_NONE=00, PAR_ODD=01, PAR_EVEN=10, PAR_NONE2=11);
  - FRAME_BITS = DATA_BITS+3.
- One natural sub-module: uart_bit_timer. It holds a loadable counter with a half-bit/full-bit terminal-count strobe and synchronous clear. The transmitter can reuse it later.

Test Plan:
- N=16, parity 01, send 0xA5 with p=1 and stop=1, rx_ready=1 -> rx_valid pulses 1 cycle; rx_word=0xA5; both error flags 0.
- N=16, parity 10, send 0xA5 with p=1 -> rx_word=0xA5, rx_parity_err=1. Repeat with parity 00 -> rx_parity_err=0.
- N=16, 0x3C with stop bit low for 3 bit-times, then high -> rx_frame_err=1; no second frame decoded during the low period; next 0x55 decodes correctly.
- Glitch: rx_data low for 5 clks with N=16 -> no rx_busy after the START check, no rx_valid, returns to IDLE.
- rx_ready=0, two frames 0x11 then 0x22 -> rx_word stays 0x11, rx_overrun=1. Then drive rx_ready=1 -> rx_valid drops, rx_overrun stays 1.
- N=1 (clamped to 2) back-to-back frames 0x00, 0xFF; and rst_n=0 asserted mid-DATA -> all outputs 0 next cycle; a following frame 0x81 decodes correctly.
